// File: rtl/chip_test_sequencer_if.sv
// Tester bank bus: shared reset, one-hot Run, per-tester Done/RSLT.
// The sequencer is the master; the tester bank is the slave.
interface chip_test_sequencer_if #(
   parameter int NUM_CHIPS = 8
);
   logic                 Tst_Reset;
   logic [NUM_CHIPS-1:0] Tst_Run;
   logic [NUM_CHIPS-1:0] Tst_Done;
   logic [NUM_CHIPS-1:0] Tst_Rslt;

   modport master (
      output Tst_Reset,
      output Tst_Run,
      input  Tst_Done,
      input  Tst_Rslt
   );

   modport slave (
      input  Tst_Reset,
      input  Tst_Run,
      output Tst_Done,
      output Tst_Rslt
   );
endinterface

// File: rtl/chip_test_sequencer.sv
// Chip tester sequencer: reset, run N times, time out hung runs,
// and report an aggregate verdict with pass/fail counts.
module chip_test_sequencer #(
   parameter int NUM_CHIPS = 8,
   parameter int SEL_W     = 3,
   parameter int CNT_W     = 8,
   parameter int TIMEOUT   = 65536,
   parameter int RST_CYC   = 2
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [SEL_W-1:0]     Sel,
   input  logic [CNT_W-1:0]     Reps,
   chip_test_sequencer_if.master tst,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Pass,
   output logic                 Timeout,
   output logic                 Bad_Sel,
   output logic [CNT_W-1:0]     Pass_Cnt,
   output logic [CNT_W-1:0]     Fail_Cnt
);

   localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int RC_W  = (RST_CYC > 2) ? $clog2(RST_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CLR,
      RUN,
      FIN
   } state_t;

   state_t               state;
   logic                 start_q;
   logic                 start_p;
   logic [SEL_W-1:0]     sel_q;
   logic [CNT_W-1:0]     reps_q;
   logic [CNT_W-1:0]     run_cnt;
   logic [TMR_W-1:0]     tmr;
   logic [RC_W-1:0]      rcnt;

   logic [NUM_CHIPS-1:0] sel_mask;
   logic [NUM_CHIPS-1:0] new_mask;
   logic                 done_sel;
   logic                 rslt_sel;
   logic                 bad_new;
   logic [CNT_W-1:0]     reps_eff;
   logic [CNT_W-1:0]     pass_nx;
   logic [CNT_W-1:0]     fail_nx;
   logic [CNT_W-1:0]     fail_sat;
   logic                 last_run;
   logic                 tmr_end;

   // Selected-tester decode, effective reps and next counter values
   always_comb begin
      sel_mask = {{(NUM_CHIPS-1){1'b0}}, 1'b1} << sel_q;
      new_mask = {{(NUM_CHIPS-1){1'b0}}, 1'b1} << Sel;
      done_sel = |(tst.Tst_Done & sel_mask);
      rslt_sel = |(tst.Tst_Rslt & sel_mask);
      bad_new  = 32'(Sel) >= NUM_CHIPS;
      reps_eff = (reps_q == '0) ? CNT_W'(1) : reps_q;
      pass_nx  = Pass_Cnt;
      fail_nx  = Fail_Cnt;
      fail_sat = (Fail_Cnt != '1) ? Fail_Cnt + 1'b1 : Fail_Cnt;
      if (rslt_sel) begin
         if (Pass_Cnt != '1)
            pass_nx = Pass_Cnt + 1'b1;
      end else begin
         fail_nx = fail_sat;
      end
      last_run = (run_cnt + 1'b1) == reps_eff;
      tmr_end  = tmr == TMR_W'(TIMEOUT - 1);
   end

   // Start edge detect, batch FSM and all registered outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state         <= IDLE;
         start_q       <= 1'b0;
         start_p       <= 1'b0;
         sel_q         <= '0;
         reps_q        <= '0;
         run_cnt       <= '0;
         tmr           <= '0;
         rcnt          <= '0;
         Busy          <= 1'b0;
         Done          <= 1'b0;
         Pass          <= 1'b0;
         Timeout       <= 1'b0;
         Bad_Sel       <= 1'b0;
         Pass_Cnt      <= '0;
         Fail_Cnt      <= '0;
         tst.Tst_Reset <= 1'b1;
         tst.Tst_Run   <= '0;
      end else begin
         start_q <= Start;
         start_p <= Start & ~start_q;
         unique case (state)
            IDLE, FIN: begin
               tst.Tst_Reset <= 1'b0;
               tst.Tst_Run   <= '0;
               if (start_p) begin
                  sel_q    <= Sel;
                  reps_q   <= Reps;
                  run_cnt  <= '0;
                  tmr      <= '0;
                  rcnt     <= '0;
                  Pass_Cnt <= '0;
                  Fail_Cnt <= '0;
                  Timeout  <= 1'b0;
                  Pass     <= 1'b0;
                  if (bad_new) begin
                     state   <= FIN;
                     Bad_Sel <= 1'b1;
                     Done    <= 1'b1;
                     Busy    <= 1'b0;
                  end else begin
                     state         <= CLR;
                     Bad_Sel       <= 1'b0;
                     Done          <= 1'b0;
                     Busy          <= 1'b1;
                     tst.Tst_Reset <= 1'b1;
                  end
               end
            end
            CLR: begin
               if (rcnt == RC_W'(RST_CYC - 1)) begin
                  state         <= RUN;
                  tmr           <= '0;
                  tst.Tst_Reset <= 1'b0;
                  tst.Tst_Run   <= sel_mask;
               end else begin
                  rcnt <= rcnt + 1'b1;
               end
            end
            RUN: begin
               if (done_sel) begin
                  Pass_Cnt    <= pass_nx;
                  Fail_Cnt    <= fail_nx;
                  run_cnt     <= run_cnt + 1'b1;
                  tst.Tst_Run <= '0;
                  if (last_run) begin
                     state <= FIN;
                     Busy  <= 1'b0;
                     Done  <= 1'b1;
                     Pass  <= (fail_nx == '0) && (pass_nx == reps_eff);
                  end else begin
                     state         <= CLR;
                     rcnt          <= '0;
                     tst.Tst_Reset <= 1'b1;
                  end
               end else if (tmr_end) begin
                  state       <= FIN;
                  Fail_Cnt    <= fail_sat;
                  Timeout     <= 1'b1;
                  Busy        <= 1'b0;
                  Done        <= 1'b1;
                  Pass        <= 1'b0;
                  tst.Tst_Run <= '0;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Directed bench for chip_test_sequencer: one task per scenario,
// tester responses driven by hand on the falling edge.
module tb_chip_test_sequencer;

   localparam int NC = 8;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Start = 1'b0;
   logic [3:0] Sel = '0;
   logic [7:0] Reps = '0;
   logic       Busy, Done, Pass, Timeout, Bad_Sel;
   logic [7:0] Pass_Cnt, Fail_Cnt;

   int errors = 0;
   int checks = 0;
   int run_rises = 0;
   logic [NC-1:0] run_prev = '0;

   chip_test_sequencer_if #(.NUM_CHIPS(NC)) tif ();

   chip_test_sequencer #(
      .NUM_CHIPS(NC),
      .SEL_W(4),
      .CNT_W(8),
      .TIMEOUT(64),
      .RST_CYC(2)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .Start(Start),
      .Sel(Sel),
      .Reps(Reps),
      .tst(tif.master),
      .Busy(Busy),
      .Done(Done),
      .Pass(Pass),
      .Timeout(Timeout),
      .Bad_Sel(Bad_Sel),
      .Pass_Cnt(Pass_Cnt),
      .Fail_Cnt(Fail_Cnt)
   );

   always #5 Clk = ~Clk;

   // Count rising edges of any Run line
   always @(negedge Clk) begin
      if (|(tif.Tst_Run & ~run_prev))
         run_rises = run_rises + 1;
      run_prev = tif.Tst_Run;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic wait_run(input int idx, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge Clk);
         if (tif.Tst_Run[idx] === 1'b1)
            ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_run%0d: Tst_Run=%h never set bit", idx, tif.Tst_Run);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick(3);
      checks++;
      if ({Busy, Done, Pass, Timeout, Bad_Sel} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 00000",
                  {Busy, Done, Pass, Timeout, Bad_Sel});
      end
      checks++;
      if (tif.Tst_Reset !== 1'b1 || tif.Tst_Run !== 8'h00) begin
         errors++;
         $display("FAIL reset_tst: rst=%b run=%h want 1/00",
                  tif.Tst_Reset, tif.Tst_Run);
      end
      checks++;
      if (Pass_Cnt !== 8'd0 || Fail_Cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_cnt: %0d/%0d want 0/0", Pass_Cnt, Fail_Cnt);
      end
      Reset = 1'b0;
      tick(2);
      checks++;
      if (tif.Tst_Reset !== 1'b0 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: rst=%b busy=%b want 0/0",
                  tif.Tst_Reset, Busy);
      end
   endtask

   task automatic test_single();
      Sel = 4'd2;
      Reps = 8'd1;
      Start = 1'b1;
      tick(1);
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_early: got %b want 0", Busy);
      end
      tick(1);
      checks++;
      if (Busy !== 1'b1 || tif.Tst_Reset !== 1'b1) begin
         errors++;
         $display("FAIL single_clr: busy=%b rst=%b want 1/1",
                  Busy, tif.Tst_Reset);
      end
      tick(1);
      checks++;
      if (tif.Tst_Run !== 8'h00 || tif.Tst_Reset !== 1'b1) begin
         errors++;
         $display("FAIL single_clr2: run=%h rst=%b want 00/1",
                  tif.Tst_Run, tif.Tst_Reset);
      end
      tick(1);
      checks++;
      if (tif.Tst_Run !== 8'h04 || tif.Tst_Reset !== 1'b0) begin
         errors++;
         $display("FAIL single_run_latency: run=%h rst=%b want 04/0",
                  tif.Tst_Run, tif.Tst_Reset);
      end
      tick(9);
      tif.Tst_Done = 8'h04;
      tif.Tst_Rslt = 8'h04;
      tick(1);
      tif.Tst_Done = 8'h00;
      tif.Tst_Rslt = 8'h00;
      checks++;
      if (Done !== 1'b1 || Pass !== 1'b1 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL single_done: done=%b pass=%b busy=%b want 1/1/0",
                  Done, Pass, Busy);
      end
      checks++;
      if (Pass_Cnt !== 8'd1 || Fail_Cnt !== 8'd0 || tif.Tst_Run !== 8'h00) begin
         errors++;
         $display("FAIL single_cnt: p=%0d f=%0d run=%h want 1/0/00",
                  Pass_Cnt, Fail_Cnt, tif.Tst_Run);
      end
      Start = 1'b0;
      tick(2);
   endtask

   task automatic test_multi();
      logic [3:0] pat;
      int base;
      bit ok;
      pat = 4'b1011;
      base = run_rises;
      Sel = 4'd0;
      Reps = 8'd4;
      Start = 1'b1;
      for (int r = 0; r < 4; r++) begin
         wait_run(0, ok);
         if (!ok) break;
         if (r == 0) begin
            checks++;
            if (Done !== 1'b0) begin
               errors++;
               $display("FAIL multi_done_clear: got %b want 0", Done);
            end
         end
         tick(2);
         tif.Tst_Done = 8'h01;
         tif.Tst_Rslt = {7'b0, pat[r]};
         tick(1);
         tif.Tst_Done = 8'h00;
         tif.Tst_Rslt = 8'h00;
         if (r < 3) begin
            checks++;
            if (tif.Tst_Run !== 8'h00 || Busy !== 1'b1) begin
               errors++;
               $display("FAIL multi_run_drop%0d: run=%h busy=%b want 00/1",
                        r, tif.Tst_Run, Busy);
            end
         end
      end
      checks++;
      if (Done !== 1'b1 || Pass !== 1'b0) begin
         errors++;
         $display("FAIL multi_verdict: done=%b pass=%b want 1/0", Done, Pass);
      end
      checks++;
      if (Pass_Cnt !== 8'd3 || Fail_Cnt !== 8'd1) begin
         errors++;
         $display("FAIL multi_cnt: p=%0d f=%0d want 3/1", Pass_Cnt, Fail_Cnt);
      end
      checks++;
      if (run_rises - base != 4) begin
         errors++;
         $display("FAIL multi_run_pulses: got %0d want 4", run_rises - base);
      end
      Start = 1'b0;
      tick(2);
   endtask

   task automatic test_timeout();
      int k;
      bit ok;
      Sel = 4'd5;
      Reps = 8'd1;
      Start = 1'b1;
      wait_run(5, ok);
      k = 0;
      while (k < 200 && Done !== 1'b1) begin
         tick(1);
         k++;
      end
      checks++;
      if (k != 64) begin
         errors++;
         $display("FAIL timeout_cycles: got %0d want 64", k);
      end
      checks++;
      if (Timeout !== 1'b1 || Pass !== 1'b0 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_flags: to=%b pass=%b busy=%b want 1/0/0",
                  Timeout, Pass, Busy);
      end
      checks++;
      if (Fail_Cnt !== 8'd1 || Pass_Cnt !== 8'd0 || tif.Tst_Run !== 8'h00) begin
         errors++;
         $display("FAIL timeout_cnt: p=%0d f=%0d run=%h want 0/1/00",
                  Pass_Cnt, Fail_Cnt, tif.Tst_Run);
      end
      Start = 1'b0;
      tick(2);
   endtask

   task automatic test_bad_sel();
      int base;
      base = run_rises;
      Sel = 4'd9;
      Reps = 8'd2;
      Start = 1'b1;
      tick(2);
      checks++;
      if (Done !== 1'b1 || Bad_Sel !== 1'b1 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL badsel_flags: done=%b bad=%b busy=%b want 1/1/0",
                  Done, Bad_Sel, Busy);
      end
      checks++;
      if (Pass !== 1'b0 || Timeout !== 1'b0 || Fail_Cnt !== 8'd0) begin
         errors++;
         $display("FAIL badsel_clear: pass=%b to=%b f=%0d want 0/0/0",
                  Pass, Timeout, Fail_Cnt);
      end
      tick(6);
      checks++;
      if (run_rises != base) begin
         errors++;
         $display("FAIL badsel_run: rises=%0d want 0", run_rises - base);
      end
      Start = 1'b0;
      tick(2);
   endtask

   task automatic test_reset_mid();
      bit ok;
      Sel = 4'd3;
      Reps = 8'd3;
      Start = 1'b1;
      wait_run(3, ok);
      tick(1);
      tif.Tst_Done = 8'h08;
      tif.Tst_Rslt = 8'h08;
      tick(1);
      tif.Tst_Done = 8'h00;
      tif.Tst_Rslt = 8'h00;
      wait_run(3, ok);
      tick(2);
      Reset = 1'b1;
      tick(1);
      checks++;
      if ({Busy, Done, Pass, Timeout, Bad_Sel} !== 5'b0) begin
         errors++;
         $display("FAIL midrst_flags: got %b want 00000",
                  {Busy, Done, Pass, Timeout, Bad_Sel});
      end
      checks++;
      if (tif.Tst_Run !== 8'h00 || tif.Tst_Reset !== 1'b1 || Pass_Cnt !== 8'd0) begin
         errors++;
         $display("FAIL midrst_tst: run=%h rst=%b p=%0d want 00/1/0",
                  tif.Tst_Run, tif.Tst_Reset, Pass_Cnt);
      end
      Reset = 1'b0;
      Start = 1'b0;
      tick(4);
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || tif.Tst_Reset !== 1'b0) begin
         errors++;
         $display("FAIL midrst_idle: busy=%b done=%b rst=%b want 0/0/0",
                  Busy, Done, tif.Tst_Reset);
      end
   endtask

   task automatic test_hold_start();
      int base;
      bit ok;
      base = run_rises;
      Sel = 4'd3;
      Reps = 8'd0;
      Start = 1'b1;
      wait_run(3, ok);
      tif.Tst_Done = 8'h02;
      tif.Tst_Rslt = 8'h02;
      tick(5);
      checks++;
      if (Busy !== 1'b1 || Done !== 1'b0 || tif.Tst_Run !== 8'h08) begin
         errors++;
         $display("FAIL hold_ignore: busy=%b done=%b run=%h want 1/0/08",
                  Busy, Done, tif.Tst_Run);
      end
      tif.Tst_Done = 8'h08;
      tif.Tst_Rslt = 8'h08;
      tick(1);
      tif.Tst_Done = 8'h00;
      tif.Tst_Rslt = 8'h00;
      checks++;
      if (Done !== 1'b1 || Pass !== 1'b1 || Pass_Cnt !== 8'd1) begin
         errors++;
         $display("FAIL hold_done: done=%b pass=%b p=%0d want 1/1/1",
                  Done, Pass, Pass_Cnt);
      end
      tick(10);
      checks++;
      if (Done !== 1'b1 || Busy !== 1'b0 || run_rises - base != 1) begin
         errors++;
         $display("FAIL hold_noretrig: done=%b busy=%b rises=%0d want 1/0/1",
                  Done, Busy, run_rises - base);
      end
      Start = 1'b0;
      tick(2);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tif.Tst_Done = 8'h00;
      tif.Tst_Rslt = 8'h00;
      test_reset();
      test_single();
      test_multi();
      test_timeout();
      test_bad_sel();
      test_reset_mid();
      test_hold_start();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
